cmd_serializer: RTL and testbench

// - Host-side transmitter for the byte-wide command link into the command processor.
// - Accepts one opcode plus a 128-bit payload on an rts/rtr handshake.
// - Emits the payload as a stream of bytes on the rts/rtr byte interface, LSB byte first.

---
 rtl/cmd_serializer.sv | 152 +++++++++++++++
 tb/tb_cmd_serializer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmd_serializer.sv
// Byte-wide command link transmitter: accepts opcode + 128-bit payload and streams payload bytes LSB first.
// Optional trailing XOR checksum byte is enabled by defining CMD_SER_CKSUM_EN.
module cmd_serializer #(
  parameter int unsigned NUM_PKT_RST  = 1,
  parameter int unsigned NUM_PKT_RECT = 11,
  parameter int unsigned NUM_PKT_LINE = 11
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_in_rts,
  output logic         cmd_in_rtr,
  input  logic [7:0]   cmd_in_op,
  input  logic [127:0] cmd_in_data,
  output logic         byte_out_rts,
  input  logic         byte_out_rtr,
  output logic [7:0]   byte_out_data,
  output logic [7:0]   cmd_out,
  output logic         busy,
  output logic         err_unsup
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SEND  = 2'd1;
`ifdef CMD_SER_CKSUM_EN
  localparam logic [1:0] ST_CKSUM = 2'd2;
`endif

  logic [1:0]   state_q, state_d;
  logic [127:0] shreg_q, shreg_d;
  logic [4:0]   remaining_q, remaining_d;
  logic [7:0]   cmd_out_q, cmd_out_d;
  logic         err_q, err_d;
  logic [7:0]   data_q, data_d;
  logic         rtr_q, rts_q, busy_q;
  logic         cmd_xfc, byte_xfc, op_ok;
  logic [4:0]   op_len;
`ifdef CMD_SER_CKSUM_EN
  logic [7:0]   cksum_q, cksum_d;
`endif

  assign cmd_xfc  = cmd_in_rts & rtr_q;
  assign byte_xfc = rts_q & byte_out_rtr;

  always_comb begin
    op_ok  = 1'b1;
    op_len = 5'(NUM_PKT_RST);
    case (cmd_in_op)
      8'h00:   op_len = 5'(NUM_PKT_RST);
      8'h03:   op_len = 5'(NUM_PKT_RECT);
      8'h04:   op_len = 5'(NUM_PKT_LINE);
      default: op_ok  = 1'b0;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    remaining_d = remaining_q;
    cmd_out_d   = cmd_out_q;
    err_d       = 1'b0;
`ifdef CMD_SER_CKSUM_EN
    cksum_d     = cksum_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cmd_xfc) begin
          if (op_ok) begin
            shreg_d     = cmd_in_data;
            cmd_out_d   = cmd_in_op;
            remaining_d = op_len;
            state_d     = ST_SEND;
`ifdef CMD_SER_CKSUM_EN
            cksum_d     = 8'h00;
`endif
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_SEND: begin
        if (byte_xfc) begin
          shreg_d     = {8'h00, shreg_q[127:8]};
          remaining_d = remaining_q - 5'd1;
`ifdef CMD_SER_CKSUM_EN
          cksum_d     = cksum_q ^ shreg_q[7:0];
          if (remaining_q == 5'd1) state_d = ST_CKSUM;
`else
          if (remaining_q == 5'd1) state_d = ST_IDLE;
`endif
        end
      end
`ifdef CMD_SER_CKSUM_EN
      ST_CKSUM: begin
        if (byte_xfc) state_d = ST_IDLE;
      end
`endif
      default: state_d = ST_IDLE;
    endcase

    // Output byte is precomputed from the next state so the port is a plain flop.
    data_d = 8'h00;
    if (state_d == ST_SEND) data_d = shreg_d[7:0];
`ifdef CMD_SER_CKSUM_EN
    if (state_d == ST_CKSUM) data_d = cksum_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      shreg_q     <= '0;
      remaining_q <= '0;
      cmd_out_q   <= '0;
      err_q       <= 1'b0;
      data_q      <= '0;
      rtr_q       <= 1'b1;
      rts_q       <= 1'b0;
      busy_q      <= 1'b0;
`ifdef CMD_SER_CKSUM_EN
      cksum_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      shreg_q     <= shreg_d;
      remaining_q <= remaining_d;
      cmd_out_q   <= cmd_out_d;
      err_q       <= err_d;
      data_q      <= data_d;
      rtr_q       <= (state_d == ST_IDLE);
      rts_q       <= (state_d != ST_IDLE);
      busy_q      <= (state_d != ST_IDLE);
`ifdef CMD_SER_CKSUM_EN
      cksum_q     <= cksum_d;
`endif
    end
  end

  always_ff @(posedge clk) begin
    assert (NUM_PKT_RST >= 1 && NUM_PKT_RST <= 16 &&
            NUM_PKT_RECT >= 1 && NUM_PKT_RECT <= 16 &&
            NUM_PKT_LINE >= 1 && NUM_PKT_LINE <= 16)
      else $error("cmd_serializer: NUM_PKT parameters must lie in 1..16");
  end

  assign cmd_in_rtr    = rtr_q;
  assign byte_out_rts  = rts_q;
  assign byte_out_data = data_q;
  assign cmd_out       = cmd_out_q;
  assign busy          = busy_q;
  assign err_unsup     = err_q;

endmodule

// File: tb/tb_cmd_serializer.sv
// Scoreboard bench for cmd_serializer: stimulus pushes expected bytes, a negedge monitor pops and compares.
// Honours CMD_SER_CKSUM_EN in the reference model when the macro is defined for the build.
module tb_cmd_serializer;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_in_rts;
  logic         cmd_in_rtr;
  logic [7:0]   cmd_in_op;
  logic [127:0] cmd_in_data;
  logic         byte_out_rts;
  logic         byte_out_rtr;
  logic [7:0]   byte_out_data;
  logic [7:0]   cmd_out;
  logic         busy;
  logic         err_unsup;

  typedef struct {
    logic [7:0] data;
    logic [7:0] op;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;
  int   err_seen = 0;
  int   exp_err = 0;
  int   rtr_mode = 0;
  logic [3:0] stall_pat = 4'b1001;
  logic       stall_pend = 1'b0;
  logic [7:0] stall_data = 8'h00;

`ifdef CMD_SER_CKSUM_EN
  localparam int CK_EXTRA = 1;
`else
  localparam int CK_EXTRA = 0;
`endif

  cmd_serializer dut (
    .clk(clk), .rst(rst),
    .cmd_in_rts(cmd_in_rts), .cmd_in_rtr(cmd_in_rtr),
    .cmd_in_op(cmd_in_op), .cmd_in_data(cmd_in_data),
    .byte_out_rts(byte_out_rts), .byte_out_rtr(byte_out_rtr),
    .byte_out_data(byte_out_data), .cmd_out(cmd_out),
    .busy(busy), .err_unsup(err_unsup)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int pkt_len(input logic [7:0] op);
    if (op == 8'h00) return 1;
    if (op == 8'h03 || op == 8'h04) return 11;
    return 0;
  endfunction

  // Reference: byte k is payload[8k+:8]; optional trailing byte is XOR of those bytes.
  task automatic push_expected(input logic [7:0] op, input logic [127:0] d);
    int n;
    logic [7:0] x;
    exp_t e;
    n = pkt_len(op);
    x = 8'h00;
    if (n == 0) exp_err++;
    for (int k = 0; k < n; k++) begin
      e.data = d[8*k +: 8];
      e.op   = op;
      x      = x ^ e.data;
      exp_q.push_back(e);
    end
    if (n != 0 && CK_EXTRA == 1) begin
      e.data = x;
      e.op   = op;
      exp_q.push_back(e);
    end
  endtask

  task automatic send_cmd(input logic [7:0] op, input logic [127:0] d);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    cmd_in_rts  = 1'b1;
    cmd_in_op   = op;
    cmd_in_data = d;
    @(negedge clk);
    while (!cmd_in_rtr && waited < 400) begin
      @(negedge clk);
      waited++;
    end
    if (!cmd_in_rtr) begin
      chk("accept_timeout", 128'(cmd_in_rtr), 128'(1));
      cmd_in_rts = 1'b0;
      return;
    end
    push_expected(op, d);
    $display("cmd op=%02h data=%032h bytes=%0d", op, d, pkt_len(op) == 0 ? 0 : pkt_len(op) + CK_EXTRA);
    @(posedge clk); #1;
    cmd_in_rts  = 1'b0;
    cmd_in_op   = 8'($urandom);
    cmd_in_data = {$urandom, $urandom, $urandom, $urandom};
  endtask

  task automatic count_busy(output int n, output logic first_rts);
    n = 0;
    @(negedge clk);
    first_rts = byte_out_rts;
    while (busy && n < 400) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while ((busy || exp_q.size() != 0) && t < 3000) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue_empty", 128'(exp_q.size()), 128'(0));
    chk("drain_busy_low", 128'(busy), 128'(0));
  endtask

  // Monitor: pops on every byte handshake and checks stall stability.
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      stall_pend = 1'b0;
    end else begin
      if (err_unsup) err_seen++;
      if (stall_pend) begin
        chk("stall_rts_held", 128'(byte_out_rts), 128'(1));
        chk("stall_data_held", 128'(byte_out_data), 128'(stall_data));
      end
      stall_pend = byte_out_rts && !byte_out_rtr;
      stall_data = byte_out_data;
      if (byte_out_rts && byte_out_rtr) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 128'(byte_out_data), 128'hx);
        end else begin
          e = exp_q.pop_front();
          chk("byte_data", 128'(byte_out_data), 128'(e.data));
          chk("cmd_out_during_xfer", 128'(cmd_out), 128'(e.op));
        end
      end
    end
  end

  // Receiver ready generator: 0 always ready, 1 random, 2 pattern 1,0,0,1.
  initial begin
    int pidx;
    pidx = 0;
    byte_out_rtr = 1'b1;
    forever begin
      @(posedge clk); #1;
      case (rtr_mode)
        0: byte_out_rtr = 1'b1;
        1: byte_out_rtr = ($urandom_range(0, 3) != 0);
        default: begin
          byte_out_rtr = stall_pat[pidx % 4];
          pidx++;
        end
      endcase
    end
  end

  initial begin
    int n;
    logic fr;
    logic [127:0] line_d, rect_d;
    line_d = 128'h0A09_0807_0605_0403_0201_00;
    rect_d = 128'h0B0A_0908_0706_0504_0302_01;
    rst = 1'b1;
    cmd_in_rts = 1'b0;
    cmd_in_op = 8'h00;
    cmd_in_data = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cmd_in_rtr", 128'(cmd_in_rtr), 128'(1));
    chk("rst_byte_out_rts", 128'(byte_out_rts), 128'(0));
    chk("rst_byte_out_data", 128'(byte_out_data), 128'(0));
    chk("rst_cmd_out", 128'(cmd_out), 128'(0));
    chk("rst_busy", 128'(busy), 128'(0));
    chk("rst_err_unsup", 128'(err_unsup), 128'(0));

    // Line draw, receiver always ready: bytes on consecutive cycles.
    send_cmd(8'h04, line_d);
    count_busy(n, fr);
    chk("line_rts_latency1", 128'(fr), 128'(1));
    chk("line_busy_cycles", 128'(n), 128'(11 + CK_EXTRA));
    chk("line_rtr_back", 128'(cmd_in_rtr), 128'(1));
    chk("line_cmd_out_idle", 128'(cmd_out), 128'(8'h04));
    wait_idle();

    // Unsupported opcode.
    send_cmd(8'h07, {$urandom, $urandom, $urandom, $urandom});
    @(negedge clk);
    chk("unsup_err_pulse", 128'(err_unsup), 128'(1));
    chk("unsup_rts_low", 128'(byte_out_rts), 128'(0));
    chk("unsup_cmd_out_kept", 128'(cmd_out), 128'(8'h04));
    @(negedge clk);
    chk("unsup_err_one_cycle", 128'(err_unsup), 128'(0));

    // Line draw with stalls.
    rtr_mode = 2;
    send_cmd(8'h04, line_d);
    wait_idle();
    rtr_mode = 0;

    // Soft reset opcode: single byte.
    send_cmd(8'h00, 128'h01);
    count_busy(n, fr);
    chk("softrst_busy_cycles", 128'(n), 128'(1 + CK_EXTRA));
    chk("softrst_rtr_back", 128'(cmd_in_rtr), 128'(1));
    wait_idle();

    // Reset after 4 of 11 rect-fill bytes.
    send_cmd(8'h03, rect_d);
    repeat (4) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("abort_pending_bytes", 128'(exp_q.size()), 128'(7 + CK_EXTRA));
    exp_q.delete();
    chk("abort_rts", 128'(byte_out_rts), 128'(0));
    chk("abort_busy", 128'(busy), 128'(0));
    chk("abort_cmd_out", 128'(cmd_out), 128'(0));
    chk("abort_rtr", 128'(cmd_in_rtr), 128'(1));
    @(posedge clk); #1 rst = 1'b0;
    send_cmd(8'h04, line_d);
    wait_idle();

    // Full rect fill (checksum byte appears only when enabled).
    send_cmd(8'h03, rect_d);
    count_busy(n, fr);
    chk("rect_busy_cycles", 128'(n), 128'(11 + CK_EXTRA));
    wait_idle();

    // Randomized traffic with random receiver stalls.
    rtr_mode = 1;
    for (int i = 0; i < 40; i++) begin
      logic [7:0] op;
      case ($urandom_range(0, 4))
        0: op = 8'h00;
        1: op = 8'h03;
        2: op = 8'h04;
        3: op = 8'h07;
        default: op = 8'($urandom);
      endcase
      repeat ($urandom_range(0, 2)) @(posedge clk);
      send_cmd(op, {$urandom, $urandom, $urandom, $urandom});
    end
    wait_idle();
    repeat (2) @(negedge clk);
    chk("err_pulse_count", 128'(err_seen), 128'(exp_err));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
